// File: rtl/coproc_pkg.sv
// Shared definitions for the HPS-to-coprocessor instruction path: opcodes,
// instruction/status field positions and the dispatcher state encoding.
package coproc_pkg;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_WRITE   = 3'd1;
  localparam logic [2:0] OP_READ    = 3'd2;
  localparam logic [2:0] OP_INVALID = 3'd7;

  localparam int GO_BIT   = 31;
  localparam int OP_MSB   = 30;
  localparam int OP_LSB   = 28;
  localparam int ADDR_LSB = 10;
  localparam int DATA_LSB = 0;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_ERROR   = 2;
  localparam int ST_OVERRUN = 3;
  localparam int ST_RD_LSB  = 4;
  localparam int RD_W       = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

endpackage

// File: rtl/dispatch_timer.sv
// Clear/enable cycle counter; expired flags the last allowed cycle of a command.
module dispatch_timer #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable)
      count <= count + W'(1);
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/instr_dispatcher.sv
// Turns go-bit edges on the HPS instruction word into one handshaked command
// for the image coprocessor and publishes a fully registered status word.
module instr_dispatcher
  import coproc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int ADDR_W         = 17,
  parameter int DATA_W         = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       instr,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [2:0]        cmd_opcode,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_done,
  input  logic [DATA_W-1:0] rsp_data,
  output logic [31:0]       status
);

  state_t          state;
  logic            go_q;
  logic            go_edge;
  logic            accept;
  logic            expired;
  logic [2:0]      op_in;
  logic            done;
  logic            error;
  logic            overrun;
  logic [RD_W-1:0] rd_data;
  logic            unused_instr;

  assign op_in        = instr[OP_MSB:OP_LSB];
  assign go_edge      = instr[GO_BIT] & ~go_q;
  assign accept       = go_edge && (state == IDLE);
  assign unused_instr = ^{instr[27], instr[9:8]};

  dispatch_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (accept),
    .enable (state != IDLE),
    .expired(expired)
  );

  // Completion is checked before expiry so a cmd_done on the timeout cycle wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      go_q       <= 1'b0;
      cmd_opcode <= '0;
      cmd_addr   <= '0;
      cmd_data   <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      overrun    <= 1'b0;
      rd_data    <= '0;
    end else begin
      go_q <= instr[GO_BIT];
      case (state)
        IDLE: begin
          if (go_edge) begin
            cmd_opcode <= op_in;
            cmd_addr   <= instr[ADDR_LSB +: ADDR_W];
            cmd_data   <= instr[DATA_LSB +: DATA_W];
            done       <= 1'b0;
            error      <= 1'b0;
            overrun    <= 1'b0;
            if (op_in == OP_NOP) begin
              done <= 1'b1;
            end else if (op_in == OP_INVALID) begin
              done  <= 1'b1;
              error <= 1'b1;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (go_edge)
            overrun <= 1'b1;
          if (expired) begin
            state <= IDLE;
            done  <= 1'b1;
            error <= 1'b1;
          end else if (cmd_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (go_edge)
            overrun <= 1'b1;
          if (cmd_done) begin
            state <= IDLE;
            done  <= 1'b1;
            if (cmd_opcode == OP_READ)
              rd_data <= RD_W'(rsp_data);
          end else if (expired) begin
            state <= IDLE;
            done  <= 1'b1;
            error <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_valid = (state == ISSUE);

  always_comb begin
    status                           = '0;
    status[ST_BUSY]                  = (state != IDLE);
    status[ST_DONE]                  = done;
    status[ST_ERROR]                 = error;
    status[ST_OVERRUN]               = overrun;
    status[ST_RD_LSB +: RD_W]        = rd_data;
  end

endmodule

// File: tb/tb_instr_dispatcher.sv
// Directed bench for instr_dispatcher: status checks at each step plus a
// scoreboard that matches every accepted command against the expected queue.
module tb_instr_dispatcher;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 8;

  typedef struct packed {
    logic [2:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [31:0]       instr;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_opcode;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_done;
  logic [DATA_W-1:0] rsp_data;
  logic [31:0]       status;

  int   compared   = 0;
  int   mismatched = 0;
  cmd_t exp_q[$];

  instr_dispatcher #(
    .TIMEOUT_CYCLES(16),
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .instr     (instr),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_opcode(cmd_opcode),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .cmd_done  (cmd_done),
    .rsp_data  (rsp_data),
    .status    (status)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a go-high instruction; only commands that must reach the handshake are queued.
  task automatic apply_stimulus(input logic [2:0] op, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] data, input bit expect_cmd);
    cmd_t c;
    c.op   = op;
    c.addr = addr;
    c.data = data;
    if (expect_cmd)
      exp_q.push_back(c);
    instr = {1'b1, op, 1'b0, addr, 2'b00, data};
  endtask

  task automatic drop_go();
    instr[31] = 1'b0;
    tick();
  endtask

  always @(negedge clk) begin
    if (reset_n && cmd_valid && cmd_ready) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_cmd", {29'b0, cmd_opcode}, 32'hFFFF_FFFF);
      end else begin
        cmd_t e;
        e = exp_q.pop_front();
        check_output("sb_opcode", {29'b0, cmd_opcode}, {29'b0, e.op});
        check_output("sb_addr", {15'b0, cmd_addr}, {15'b0, e.addr});
        check_output("sb_data", {24'b0, cmd_data}, {24'b0, e.data});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    instr     = '0;
    cmd_ready = 1'b0;
    cmd_done  = 1'b0;
    rsp_data  = '0;
    #12;
    check_output("reset_status", status, 32'h0);
    check_output("reset_valid", {31'b0, cmd_valid}, 32'h0);
    reset_n = 1'b1;
    tick();

    // WRITE_PIXEL with ready high; go stays high afterwards to prove no retrigger.
    cmd_ready = 1'b1;
    apply_stimulus(3'd1, 17'h00123, 8'hA5, 1'b1);
    tick();
    check_output("wr_valid", {31'b0, cmd_valid}, 32'h1);
    check_output("wr_addr", {15'b0, cmd_addr}, 32'h00123);
    check_output("wr_data", {24'b0, cmd_data}, 32'hA5);
    check_output("wr_busy", status, 32'h1);
    tick();
    check_output("wr_wait_valid", {31'b0, cmd_valid}, 32'h0);
    check_output("wr_wait_status", status, 32'h1);
    tick();
    tick();
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    check_output("wr_done_status", status, 32'h2);
    tick();
    tick();
    check_output("go_held_no_retrigger", status, 32'h2);
    check_output("go_held_valid", {31'b0, cmd_valid}, 32'h0);

    // READ_PIXEL with ready held low for five cycles.
    drop_go();
    cmd_ready = 1'b0;
    apply_stimulus(3'd2, 17'h1ABCD, 8'h00, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      check_output($sformatf("rd_valid_stable_%0d", i), {31'b0, cmd_valid}, 32'h1);
      check_output($sformatf("rd_addr_stable_%0d", i), {15'b0, cmd_addr}, 32'h1ABCD);
      tick();
    end
    cmd_ready = 1'b1;
    check_output("rd_valid_cycle6", {31'b0, cmd_valid}, 32'h1);
    tick();
    cmd_ready = 1'b0;
    check_output("rd_wait_valid", {31'b0, cmd_valid}, 32'h0);
    cmd_done = 1'b1;
    rsp_data = 8'h3C;
    tick();
    cmd_done = 1'b0;
    rsp_data = 8'h00;
    check_output("rd_done_status", status, 32'h3C2);

    // Invalid opcode then NOP: rd_data must survive both.
    drop_go();
    apply_stimulus(3'd7, 17'h0, 8'h0, 1'b0);
    tick();
    check_output("inv_status", status, 32'h3C6);
    check_output("inv_valid", {31'b0, cmd_valid}, 32'h0);
    drop_go();
    check_output("inv_no_busy", status, 32'h3C6);
    apply_stimulus(3'd0, 17'h0, 8'h0, 1'b0);
    tick();
    check_output("nop_status", status, 32'h3C2);

    // Timeout: ready and done never assert, error appears after 16 busy cycles.
    drop_go();
    apply_stimulus(3'd1, 17'h00005, 8'h07, 1'b0);
    tick();
    for (int i = 0; i < 16; i++) begin
      check_output($sformatf("to_busy_%0d", i), status, 32'h3C1);
      tick();
    end
    check_output("to_status", status, 32'h3C6);
    check_output("to_valid", {31'b0, cmd_valid}, 32'h0);

    // Overrun: a second edge during WAIT is discarded and flagged.
    drop_go();
    cmd_ready = 1'b1;
    apply_stimulus(3'd3, 17'h00042, 8'h11, 1'b1);
    tick();
    tick();
    check_output("ov_wait_status", status, 32'h3C1);
    drop_go();
    apply_stimulus(3'd1, 17'h00777, 8'h22, 1'b0);
    tick();
    check_output("ov_flag", status, 32'h3C9);
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    check_output("ov_done_status", status, 32'h3CA);
    tick();
    tick();
    tick();
    check_output("ov_no_second_cmd", status, 32'h3CA);

    // Asynchronous reset while in ISSUE, then a fresh command at the address boundary.
    drop_go();
    cmd_ready = 1'b0;
    apply_stimulus(3'd1, 17'h1FFFF, 8'hFF, 1'b0);
    tick();
    check_output("rst_pre_valid", {31'b0, cmd_valid}, 32'h1);
    #2;
    reset_n = 1'b0;
    instr   = '0;
    #1;
    check_output("rst_async_valid", {31'b0, cmd_valid}, 32'h0);
    check_output("rst_async_status", status, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    cmd_ready = 1'b1;
    apply_stimulus(3'd1, 17'h1FFFF, 8'hFF, 1'b1);
    tick();
    check_output("post_rst_valid", {31'b0, cmd_valid}, 32'h1);
    check_output("post_rst_addr", {15'b0, cmd_addr}, 32'h1FFFF);
    tick();
    cmd_ready = 1'b0;
    cmd_done  = 1'b1;
    tick();
    cmd_done = 1'b0;
    check_output("post_rst_done", status, 32'h2);

    tick();
    check_output("sb_queue_empty", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instr_dispatcher.md
# instr_dispatcher

Consumes the 32-bit instruction word driven by the HPS instruction PIO and turns each new instruction into one handshaked command for the image coprocessor core. It detects a rising edge on the instruction's go bit, decodes and latches the fields, issues the command with a valid/ready handshake, waits for completion with a timeout, and publishes a status word for the HPS status input PIO. Same `clk` domain as the PIO, so no synchronisers are needed.

## Interface
- `TIMEOUT_CYCLES`, default 1000000: maximum cycles from acceptance to completion before an error is flagged.
- `ADDR_W`, default 17: pixel address width (covers 320x240).
- `DATA_W`, default 8: pixel data width.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `instr`  in  32  instruction word from the PIO. Field layout:
  - [31] go
  - [30:28] opcode
  - [26:10] addr
  - [7:0] data
  - all other bits ignored.
- `cmd_valid`  out  1  command offered to the coprocessor.
- `cmd_ready`  in  1  coprocessor accepts the command.
- `cmd_opcode`  out  3  latched opcode.
- `cmd_addr`  out  ADDR_W  latched address.
- `cmd_data`  out  DATA_W  latched write data.
- `cmd_done`  in  1  single-cycle completion pulse from the coprocessor.
- `rsp_data`  in  DATA_W  read data, valid with `cmd_done`.
- `status`  out  32  status word:
  - [0] busy
  - [1] done
  - [2] error
  - [3] overrun
  - [11:4] rd_data
  - [31:12] zero.

## Operation
- Opcodes:
  - 0 NOP
  - 1 WRITE_PIXEL
  - 2 READ_PIXEL
  - 3–6 algorithm select, passed through
  - 7 invalid.
- Go edge: `go_q` registers `instr[31]`. An edge is `instr[31] & ~go_q`. Only edges in IDLE are accepted. Level-high go never retriggers.
- On acceptance:
  - Latch opcode, addr and data.
  - Clear done, error, overrun and the timer.
  - rd_data keeps its value until the next READ completes.
- States:
  - IDLE:
    - Edge with opcode 1–6 → ISSUE.
    - Edge with opcode 0 → IDLE, done=1.
    - Edge with opcode 7 → IDLE, done=1, error=1.
  - ISSUE: `cmd_valid`=1. Fields stay stable until `cmd_valid & cmd_ready`, then → WAIT.
  - WAIT: `cmd_done` → IDLE with done=1. If opcode=2, rd_data ← `rsp_data` in the same cycle.
- `cmd_done` is ignored outside WAIT. A `cmd_done` coincident with the handshake cycle is ignored.
- Timeout:
  - The timer counts every cycle in ISSUE or WAIT.
  - When it reaches TIMEOUT_CYCLES-1 without completion → IDLE with done=1, error=1, and `cmd_valid` drops.
  - Completion in the same cycle as the timeout wins: no error.
- Overrun: a go edge seen in ISSUE or WAIT sets overrun=1 (sticky until the next acceptance). The instruction is discarded.
- busy=1 exactly in ISSUE and WAIT.

## Timing
- Reset values: all outputs 0, state IDLE, `go_q`=0, timer 0. Reset mid-command drops `cmd_valid` immediately (asynchronous).
- Edge sampled in cycle N → `cmd_valid`/busy high from N+1.
- NOP/invalid: done (and error for invalid) visible at N+1, busy never rises.
- Handshake in cycle M → `cmd_valid` low and state WAIT at M+1.
- `cmd_done` in cycle K → busy=0, done=1 and rd_data valid at K+1. A new edge is acceptable at K+1.
- Status is fully registered: no combinational path from any input to `status`.

## Structure
- Package `coproc_pkg` holds:
  - opcode constants
  - instruction field bit positions
  - status bit positions
  - state enum (IDLE, ISSUE, WAIT)
- Sub-module `dispatch_timer`: clear/enable counter with a `$clog2(TIMEOUT_CYCLES)` width and an `expired` output. All other logic stays in `instr_dispatcher`.

## Test plan
- WRITE_PIXEL (go=1, op=1, addr=0x00123, data=0xA5), `cmd_ready` high → `cmd_valid` at N+1 with addr=0x00123, data=0xA5. `cmd_done` 3 cycles later → status=0x2.
- READ_PIXEL: hold `cmd_ready` low 5 cycles, then `cmd_done` with `rsp_data`=0x3C → `cmd_valid` stable for 6 cycles. Final status[11:4]=0x3C, done=1.
- Opcode 7 → no `cmd_valid`, status=0x6 at N+1. Then a NOP edge → status=0x2, with rd_data retained.
- With TIMEOUT_CYCLES=16 and `cmd_done` never asserted → done=1, error=1 at cycle 16 after acceptance, busy=0.
- Second go edge during WAIT → overrun=1, no second command. Go held high after completion → no retrigger.
- Assert reset while in ISSUE → `cmd_valid` and status go to 0 asynchronously. A fresh edge after release → normal issue.
